// File: rtl/pma_region_unit.sv
// Runtime-programmable physical memory attribute unit: NrRules lockable address windows,
// NrPorts registered lookups, programmed through a req/gnt register port.
module pma_region_unit #(
  parameter int unsigned          NrRules   = 4,
  parameter int unsigned          NrPorts   = 2,
  parameter int unsigned          AddrWidth = 64,
  parameter logic [AddrWidth-1:0] RstBase0  = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] RstLen0   = 64'h4000_0000,
  parameter logic [2:0]           RstAttr0  = 3'b011,
  parameter logic [2:0]           DefAttr   = 3'b100,
  localparam int unsigned         IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_req_i,
  input  logic                           cfg_we_i,
  input  logic [IdxWidth-1:0]            cfg_idx_i,
  input  logic [1:0]                     cfg_field_i,
  input  logic [AddrWidth-1:0]           cfg_wdata_i,
  output logic                           cfg_gnt_o,
  output logic                           cfg_rvalid_o,
  output logic [AddrWidth-1:0]           cfg_rdata_o,
  output logic                           cfg_err_o,
  input  logic [NrPorts-1:0]             lu_valid_i,
  input  logic [NrPorts*AddrWidth-1:0]   lu_addr_i,
  output logic [NrPorts-1:0]             lu_valid_o,
  output logic [NrPorts-1:0]             lu_hit_o,
  output logic [NrPorts*3-1:0]           lu_attr_o
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;
  typedef enum logic [1:0] {FieldBase, FieldLen, FieldAttr, FieldRsvd} field_e;

  // Rule table
  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [2:0]           rattr_q[NrRules];
  logic                 lock_q [NrRules];

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 idx_ok;
  logic [IdxWidth-1:0]  idx;
  logic                 acc_err;
  logic                 gnt;
  logic                 do_write;

  // ---------------------------------------------------------------------------
  // Config access decode
  // ---------------------------------------------------------------------------
  assign idx_ok  = (32'(cfg_idx_i) < NrRules);
  // Out-of-range indices are redirected to rule 0 so array reads stay in bounds.
  assign idx     = idx_ok ? cfg_idx_i : '0;
  assign acc_err = !idx_ok || (field_e'(cfg_field_i) == FieldRsvd) || (cfg_we_i && lock_q[idx]);

  assign gnt      = cfg_req_i && (state_q == StIdle);
  assign do_write = gnt && cfg_we_i && !acc_err;

  always_comb begin
    state_d = state_q;
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt) begin
          state_d = StResp;
          err_d   = acc_err;
          if (!acc_err && !cfg_we_i) begin
            unique case (field_e'(cfg_field_i))
              FieldBase: rdata_d = base_q[idx];
              FieldLen:  rdata_d = len_q[idx];
              FieldAttr: rdata_d = {{(AddrWidth-4){1'b0}}, lock_q[idx], rattr_q[idx]};
              default:   rdata_d = '0;
            endcase
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cfg_gnt_o    = gnt;
  assign cfg_rvalid_o = (state_q == StResp);
  assign cfg_rdata_o  = rdata_q;
  assign cfg_err_o    = err_q;

  // ---------------------------------------------------------------------------
  // Rule table storage; a write commits on the accepting edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        base_q[i]  <= (i == 0) ? RstBase0 : '0;
        len_q[i]   <= (i == 0) ? RstLen0  : '0;
        rattr_q[i] <= (i == 0) ? RstAttr0 : 3'b000;
        lock_q[i]  <= 1'b0;
      end
    end else if (do_write) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        if (idx == IdxWidth'(i)) begin
          unique case (field_e'(cfg_field_i))
            FieldBase: base_q[i] <= cfg_wdata_i;
            FieldLen:  len_q[i]  <= cfg_wdata_i;
            FieldAttr: begin
              rattr_q[i] <= cfg_wdata_i[2:0];
              lock_q[i]  <= cfg_wdata_i[3];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup: combinational match against the current table, registered result
  // ---------------------------------------------------------------------------
  function automatic logic rule_hit(input logic [AddrWidth-1:0] base,
                                    input logic [AddrWidth-1:0] len,
                                    input logic [AddrWidth-1:0] addr);
    logic [AddrWidth:0] limit;
    // One extra bit so windows ending at the top of the address space do not wrap.
    limit = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  logic [NrPorts-1:0] hit;
  logic [2:0]         attr [NrPorts];

  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++) begin
      hit[p]  = 1'b0;
      attr[p] = DefAttr;
      // Scan downwards so the lowest-index hitting rule is the last to overwrite.
      for (int i = int'(NrRules) - 1; i >= 0; i--) begin
        if (rule_hit(base_q[i], len_q[i], lu_addr_i[p*AddrWidth +: AddrWidth])) begin
          hit[p]  = 1'b1;
          attr[p] = rattr_q[i];
        end
      end
    end
  end

  logic [NrPorts-1:0]   lu_valid_q;
  logic [NrPorts-1:0]   lu_hit_q;
  logic [NrPorts*3-1:0] lu_attr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lu_valid_q <= '0;
      lu_hit_q   <= '0;
      lu_attr_q  <= '0;
    end else begin
      lu_valid_q <= lu_valid_i;
      for (int p = 0; p < int'(NrPorts); p++) begin
        lu_hit_q[p]         <= lu_valid_i[p] && hit[p];
        lu_attr_q[p*3 +: 3] <= lu_valid_i[p] ? attr[p] : 3'b000;
      end
    end
  end

  assign lu_valid_o = lu_valid_q;
  assign lu_hit_o   = lu_hit_q;
  assign lu_attr_o  = lu_attr_q;

endmodule

// File: tb/tb_pma_region_unit.sv
// Scoreboard bench for pma_region_unit: a driver pushes model expectations, a monitor
// pops and compares whenever the DUT presents a lookup result or config response.
module tb_pma_region_unit;

  // Three rules so that an out-of-range index (3) is representable on the 2-bit idx port.
  localparam int NR = 3;
  localparam int NP = 2;
  localparam int AW = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_req, cfg_we;
  logic [1:0]        cfg_idx, cfg_field;
  logic [AW-1:0]     cfg_wdata;
  logic              cfg_gnt, cfg_rvalid, cfg_err;
  logic [AW-1:0]     cfg_rdata;
  logic [NP-1:0]     lu_valid_in, lu_valid_out, lu_hit;
  logic [NP*AW-1:0]  lu_addr;
  logic [NP*3-1:0]   lu_attr;

  always #5 clk = ~clk;

  pma_region_unit #(
    .NrRules  (NR),
    .NrPorts  (NP),
    .AddrWidth(AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_req_i   (cfg_req),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_field_i (cfg_field),
    .cfg_wdata_i (cfg_wdata),
    .cfg_gnt_o   (cfg_gnt),
    .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o (cfg_rdata),
    .cfg_err_o   (cfg_err),
    .lu_valid_i  (lu_valid_in),
    .lu_addr_i   (lu_addr),
    .lu_valid_o  (lu_valid_out),
    .lu_hit_o    (lu_hit),
    .lu_attr_o   (lu_attr)
  );

  typedef struct {logic hit; logic [2:0] attr; logic [63:0] addr;} lu_exp_t;
  typedef struct {logic [63:0] rdata; logic err; int cyc;} cfg_exp_t;

  lu_exp_t  lu_q0[$];
  lu_exp_t  lu_q1[$];
  cfg_exp_t cfg_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  logic [63:0] m_base[NR];
  logic [63:0] m_len [NR];
  logic [2:0]  m_attr[NR];
  logic        m_lock[NR];
  bit          m_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 64'h0; m_len[i] = 64'h0; m_attr[i] = 3'b000; m_lock[i] = 1'b0;
    end
    m_base[0] = 64'h8000_0000;
    m_len[0]  = 64'h4000_0000;
    m_attr[0] = 3'b011;
    m_busy    = 1'b0;
  endtask

  // Windows are [base, base+len) on unbounded integers; first matching rule in index order wins.
  function automatic lu_exp_t lookup_ref(input logic [63:0] a);
    lu_exp_t e;
    e.hit = 1'b0; e.attr = 3'b100; e.addr = a;
    for (int i = 0; i < NR; i++) begin
      if (!e.hit && m_len[i] != 0 && a >= m_base[i] &&
          ({1'b0, a} < ({1'b0, m_base[i]} + {1'b0, m_len[i]}))) begin
        e.hit  = 1'b1;
        e.attr = m_attr[i];
      end
    end
    return e;
  endfunction

  // One clock of stimulus: drive on the falling edge, push expectations, advance the model.
  task automatic step(input bit req, input bit we, input logic [1:0] idx, input logic [1:0] field,
                      input logic [63:0] wd, input logic [1:0] lv,
                      input logic [63:0] a0, input logic [63:0] a1);
    cfg_exp_t c;
    @(negedge clk);
    cfg_req = req; cfg_we = we; cfg_idx = idx; cfg_field = field; cfg_wdata = wd;
    lu_valid_in = lv; lu_addr = {a1, a0};
    if (lv[0]) lu_q0.push_back(lookup_ref(a0));
    if (lv[1]) lu_q1.push_back(lookup_ref(a1));
    if (req) begin
      #1;
      check("cfg_gnt", cfg_gnt, !m_busy);
      if (!m_busy) begin
        c.cyc   = cyc + 1;
        c.rdata = 64'h0;
        c.err   = (idx >= NR) || (field == 2'd3);
        if (!c.err && we && m_lock[idx]) c.err = 1'b1;
        if (!c.err) begin
          if (we) begin
            case (field)
              2'd0: m_base[idx] = wd;
              2'd1: m_len[idx]  = wd;
              default: begin m_attr[idx] = wd[2:0]; m_lock[idx] = wd[3]; end
            endcase
          end else begin
            case (field)
              2'd0: c.rdata = m_base[idx];
              2'd1: c.rdata = m_len[idx];
              default: c.rdata = {60'h0, m_lock[idx], m_attr[idx]};
            endcase
          end
        end
        cfg_q.push_back(c);
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask
  task automatic lk(input logic [1:0] lv, input logic [63:0] a0, input logic [63:0] a1);
    step(0, 0, 0, 0, 0, lv, a0, a1);
  endtask
  task automatic wr(input logic [1:0] idx, input logic [1:0] field, input logic [63:0] wd);
    step(1, 1, idx, field, wd, 2'b00, 0, 0);
    idle();
  endtask
  task automatic rd(input logic [1:0] idx, input logic [1:0] field);
    step(1, 0, idx, field, 0, 2'b00, 0, 0);
    idle();
  endtask

  task automatic mon_lu(input int p);
    lu_exp_t e;
    int      sz;
    sz = (p == 0) ? lu_q0.size() : lu_q1.size();
    if (lu_valid_out[p]) begin
      if (sz == 0) begin
        tests++; fails++;
        $display("FAIL lu_unexpected port %0d: got valid 1 expected 0", p);
      end else begin
        if (p == 0) e = lu_q0.pop_front();
        else        e = lu_q1.pop_front();
        check($sformatf("lu_hit p%0d a=%0h", p, e.addr), lu_hit[p], e.hit);
        check($sformatf("lu_attr p%0d a=%0h", p, e.addr), lu_attr[p*3 +: 3], e.attr);
      end
    end else if (sz != 0) begin
      tests++; fails++;
      $display("FAIL lu_missing port %0d: got valid 0 expected 1", p);
      if (p == 0) void'(lu_q0.pop_front());
      else        void'(lu_q1.pop_front());
    end
  endtask

  task automatic mon_cfg();
    cfg_exp_t c;
    if (cfg_rvalid) begin
      if (cfg_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL cfg_unexpected_rvalid: got 1 expected 0");
      end else begin
        c = cfg_q.pop_front();
        check("cfg_rdata", cfg_rdata, c.rdata);
        check("cfg_err", cfg_err, c.err);
        check("cfg_latency", cyc, c.cyc);
      end
    end else if (cfg_q.size() != 0 && cfg_q[0].cyc <= cyc) begin
      tests++; fails++;
      $display("FAIL cfg_missing_rvalid: got 0 expected 1");
      void'(cfg_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        mon_lu(0);
        mon_lu(1);
        mon_cfg();
      end
    end
  end

  task automatic apply_reset();
    lu_q0.delete(); lu_q1.delete(); cfg_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a[2];
    logic [1:0]  fld;
    int          r;
    rst_n = 1'b0;
    cfg_req = 0; cfg_we = 0; cfg_idx = 0; cfg_field = 0; cfg_wdata = 0;
    lu_valid_in = 0; lu_addr = 0;
    model_reset();
    @(negedge clk); #1;
    check("rst_lu_valid", lu_valid_out, 0);
    check("rst_lu_hit", lu_hit, 0);
    check("rst_lu_attr", lu_attr, 0);
    check("rst_rvalid", cfg_rvalid, 0);
    check("rst_rdata", cfg_rdata, 0);
    check("rst_err", cfg_err, 0);
    apply_reset();

    // Reset table, window edges, both ports concurrently
    lk(2'b11, 64'h8000_1000, 64'h4000_0000);
    lk(2'b11, 64'hBFFF_FFFF, 64'hC000_0000);
    lk(2'b11, 64'h8000_0000, 64'h7FFF_FFFF);
    rd(0, 0); rd(0, 1); rd(0, 2);

    // Window reaching the top of the address space
    wr(1, 0, 64'hFFFF_FFFF_FFFF_F000);
    wr(1, 1, 64'h1000);
    lk(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_EFFF);
    lk(2'b01, 64'h0, 0);

    // Overlap: rule 0 beats rule 1
    wr(1, 0, 64'h8000_0000);
    wr(1, 2, 64'h4);
    lk(2'b11, 64'h8000_0800, 64'h8000_1000);

    // Lock
    wr(2, 2, 64'h9);
    wr(2, 0, 64'h1234);
    rd(2, 0); rd(2, 2);
    wr(2, 2, 64'h2);
    rd(2, 2);

    // Errors: out-of-range index, reserved field
    rd(3, 0);
    wr(3, 1, 64'h55);
    rd(0, 3);

    // Back-to-back request: second one must not be granted in the response cycle
    step(1, 0, 0, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 1, 0, 2'b00, 0, 0);
    step(1, 0, 0, 1, 0, 2'b00, 0, 0);
    idle();

    // Write and lookup in the same cycle: lookup sees the pre-write table
    wr(1, 1, 64'h0);
    step(1, 1, 0, 1, 64'h0, 2'b01, 64'h8000_0000, 0);
    lk(2'b01, 64'h8000_0000, 0);
    idle();

    // Reset during the response cycle drops the response and restores the table
    step(1, 0, 0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    cfg_req = 0; lu_valid_in = 0;
    #1;
    check("rst_mid_resp_rvalid", cfg_rvalid, 0);
    apply_reset();
    lk(2'b11, 64'h8000_0000, 64'hBFFF_FFFF);
    rd(1, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, NR - 1);
        case ($urandom_range(0, 5))
          0: a[p] = m_base[r];
          1: a[p] = m_base[r] - 64'h1;
          2: a[p] = m_base[r] + m_len[r];
          3: a[p] = m_base[r] + m_len[r] - 64'h1;
          4: a[p] = 64'h8000_0000 + 64'($urandom_range(0, 32'h0004_0000));
          default: a[p] = {$urandom, $urandom};
        endcase
      end
      fld = 2'($urandom_range(0, 3));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), fld,
           (fld == 2'd0) ? 64'h8000_0000 + 64'($urandom_range(0, 32'h0003_0000)) :
           (fld == 2'd1) ? 64'($urandom_range(0, 32'h0002_0000)) :
                           {60'h0, $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7))},
           2'($urandom_range(0, 3)), a[0], a[1]);
    end
    idle(); idle(); idle();
    check("drain_lu0", lu_q0.size(), 0);
    check("drain_lu1", lu_q1.size(), 0);
    check("drain_cfg", cfg_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
